// File: rtl/id_hazard_ctrl_pkg.sv
// Shared types and codes for the decode-side hazard/forwarding controller.
// Holds the scoreboard entry layout, operand-mux codes and FSM state encoding.
package id_hazard_ctrl_pkg;

    typedef struct packed {
        logic [4:0] rd;
        logic       wr;
        logic       ld;
    } sb_entry_t;

    localparam int SB_ENTRY_W = $bits(sb_entry_t);

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EXM = 2'b01;
    localparam logic [1:0] FWD_MWB = 2'b10;
    localparam logic [1:0] FWD_WBL = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } state_t;

endpackage

// File: rtl/haz_fwd_sel.sv
// One source operand compared against the EX/MEM/WB scoreboard slots.
// Returns the operand-mux code and whether the value cannot be delivered yet.
module haz_fwd_sel
    import id_hazard_ctrl_pkg::*;
#(
    parameter int LOAD_STALL = 1
) (
    input  logic [4:0] src,
    input  logic       use_src,
    input  sb_entry_t  slot_e,
    input  sb_entry_t  slot_m,
    input  sb_entry_t  slot_w,
    output logic [1:0] fwd,
    output logic       hazard
);

    logic live;
    logic hit_e;
    logic hit_m;
    logic hit_w;

    always_comb begin
        live   = use_src && (src != 5'd0);
        hit_e  = live && slot_e.wr && (slot_e.rd == src);
        hit_m  = live && slot_m.wr && (slot_m.rd == src);
        hit_w  = live && slot_w.wr && (slot_w.rd == src);
        fwd    = FWD_RF;
        hazard = 1'b0;
        // Nearest producer wins; an older slot is never consulted once a younger one hits.
        if (hit_e) begin
            if (slot_e.ld) begin
                hazard = 1'b1;
            end else begin
                fwd = FWD_EXM;
            end
        end else if (hit_m) begin
            if (slot_m.ld && (LOAD_STALL == 2)) begin
                fwd    = FWD_WBL;
                hazard = 1'b1;
            end else begin
                fwd = FWD_MWB;
            end
        end else if (hit_w) begin
            fwd = FWD_WBL;
        end
    end

endmodule

// File: rtl/id_hazard_ctrl.sv
// Decode-side hazard and forwarding controller feeding the ID/EX register.
// Optional event counters StallCnt/FlushCnt are built when HAZ_PERF_EN is defined.
//
//  state    | meaning
//  ---------+------------------------------------------------
//  ST_RUN   | last edge issued normally
//  ST_STALL | last edge held PC and IF/ID, bubbled ID/EX
//  ST_FLUSH | last edge redirected on jr, cleared IF/ID and ID/EX
module id_hazard_ctrl
    import id_hazard_ctrl_pkg::*;
#(
    parameter int LOAD_STALL = 1
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [4:0]  dRs,
    input  logic [4:0]  dRt,
    input  logic        dUseRs,
    input  logic        dUseRt,
    input  logic [4:0]  dRd,
    input  logic        dWreg,
    input  logic        dLoad,
    input  logic        exJr,
    output logic [1:0]  FwdA,
    output logic [1:0]  FwdB,
    output logic        PcEn,
    output logic        IfidEn,
    output logic        IfidClrn,
    output logic        IdexClrn,
    output logic [1:0]  State
`ifdef HAZ_PERF_EN
    ,
    output logic [31:0] StallCnt,
    output logic [31:0] FlushCnt
`endif
);

    sb_entry_t slot_e;
    sb_entry_t slot_m;
    sb_entry_t slot_w;
    sb_entry_t new_entry;

    state_t state_q;
    state_t state_d;

    logic haz_a;
    logic haz_b;
    logic stall;
    logic flush;
    logic issue;

    haz_fwd_sel #(.LOAD_STALL(LOAD_STALL)) u_sel_rs (
        .src     (dRs),
        .use_src (dUseRs),
        .slot_e  (slot_e),
        .slot_m  (slot_m),
        .slot_w  (slot_w),
        .fwd     (FwdA),
        .hazard  (haz_a)
    );

    haz_fwd_sel #(.LOAD_STALL(LOAD_STALL)) u_sel_rt (
        .src     (dRt),
        .use_src (dUseRt),
        .slot_e  (slot_e),
        .slot_m  (slot_m),
        .slot_w  (slot_w),
        .fwd     (FwdB),
        .hazard  (haz_b)
    );

    always_comb begin
        stall        = haz_a | haz_b;
        flush        = exJr;
        issue        = !stall && !flush;
        new_entry.rd = dRd;
        new_entry.wr = dWreg && (dRd != 5'd0);
        new_entry.ld = dLoad;
    end

    // Scoreboard advances every edge; a held or flushed decode slot enters EX as a bubble.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            slot_e <= '0;
            slot_m <= '0;
            slot_w <= '0;
        end else begin
            slot_w <= slot_m;
            slot_m <= slot_e;
            slot_e <= issue ? new_entry : '0;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = ST_RUN;
        PcEn     = 1'b1;
        IfidEn   = 1'b1;
        IfidClrn = 1'b1;
        IdexClrn = 1'b1;
        if (flush) begin
            state_d  = ST_FLUSH;
            IfidClrn = 1'b0;
            IdexClrn = 1'b0;
        end else if (stall) begin
            state_d  = ST_STALL;
            PcEn     = 1'b0;
            IfidEn   = 1'b0;
            IdexClrn = 1'b0;
        end
    end

    assign State = state_q;

`ifdef HAZ_PERF_EN
    // A stall masked by a same-cycle flush is not counted as a stall.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            StallCnt <= '0;
            FlushCnt <= '0;
        end else begin
            if (stall && !flush) begin
                StallCnt <= StallCnt + 32'd1;
            end
            if (flush) begin
                FlushCnt <= FlushCnt + 32'd1;
            end
        end
    end
`else
    // Event counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Self-checking bench: two instances (LOAD_STALL 1 and 2) share stimulus and are
// compared each cycle against a distance-based producer/consumer reference model.
module tb_id_hazard_ctrl;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic [4:0] dRs = '0, dRt = '0, dRd = '0;
    logic       dUseRs = 1'b0, dUseRt = 1'b0, dWreg = 1'b0, dLoad = 1'b0, exJr = 1'b0;

    logic [1:0] fa1, fb1, st1, fa2, fb2, st2;
    logic       pc1, ie1, ic1, xc1, pc2, ie2, ic2, xc2;
`ifdef HAZ_PERF_EN
    logic [31:0] sc1, fc1, sc2, fc2;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: index 0 = one stage ahead of ID (EX), 1 = MEM, 2 = WB.
    logic [4:0] mrd [2][3];
    bit         mwr [2][3];
    bit         mld [2][3];
    logic [1:0] mst [2];
    int unsigned msc [2];
    int unsigned mfc [2];

    always #5 Clk = ~Clk;

    id_hazard_ctrl #(.LOAD_STALL(1)) u_ls1 (
        .Clk(Clk), .Rst(Rst), .dRs(dRs), .dRt(dRt), .dUseRs(dUseRs), .dUseRt(dUseRt),
        .dRd(dRd), .dWreg(dWreg), .dLoad(dLoad), .exJr(exJr),
        .FwdA(fa1), .FwdB(fb1), .PcEn(pc1), .IfidEn(ie1), .IfidClrn(ic1), .IdexClrn(xc1),
        .State(st1)
`ifdef HAZ_PERF_EN
        , .StallCnt(sc1), .FlushCnt(fc1)
`endif
    );

    id_hazard_ctrl #(.LOAD_STALL(2)) u_ls2 (
        .Clk(Clk), .Rst(Rst), .dRs(dRs), .dRt(dRt), .dUseRs(dUseRs), .dUseRt(dUseRt),
        .dRd(dRd), .dWreg(dWreg), .dLoad(dLoad), .exJr(exJr),
        .FwdA(fa2), .FwdB(fb2), .PcEn(pc2), .IfidEn(ie2), .IfidClrn(ic2), .IdexClrn(xc2),
        .State(st2)
`ifdef HAZ_PERF_EN
        , .StallCnt(sc2), .FlushCnt(fc2)
`endif
    );

    // {FwdA, FwdB, PcEn, IfidEn, IfidClrn, IdexClrn, State}
    function automatic logic [9:0] obs(input int k);
        if (k == 0) return {fa1, fb1, pc1, ie1, ic1, xc1, st1};
        return {fa2, fb2, pc2, ie2, ic2, xc2, st2};
    endfunction

    // A value produced d stages ahead is usable unless it is a load still
    // fewer than LOAD_STALL (= k+1) stages away.
    function automatic void src_eval(input int k, input logic [4:0] src, input logic use_it,
                                     output logic [1:0] code, output logic haz);
        code = 2'd0;
        haz  = 1'b0;
        if (!use_it || src == 5'd0) return;
        for (int d = 0; d < 3; d++) begin
            if (mwr[k][d] && mrd[k][d] == src) begin
                haz = mld[k][d] && (d < k + 1);
                if (d == 0)      code = mld[k][d] ? 2'd0 : 2'd1;
                else if (d == 1) code = (mld[k][d] && k == 1) ? 2'd3 : 2'd2;
                else             code = 2'd3;
                return;
            end
        end
    endfunction

    function automatic logic model_stall(input int k);
        logic [1:0] c;
        logic ha, hb;
        src_eval(k, dRs, dUseRs, c, ha);
        src_eval(k, dRt, dUseRt, c, hb);
        return ha | hb;
    endfunction

    function automatic logic [9:0] model_out(input int k);
        logic [1:0] fa, fb;
        logic ha, hb;
        logic [3:0] ctl;
        src_eval(k, dRs, dUseRs, fa, ha);
        src_eval(k, dRt, dUseRt, fb, hb);
        if (exJr)          ctl = 4'b1100;
        else if (ha || hb) ctl = 4'b0010;
        else               ctl = 4'b1111;
        return {fa, fb, ctl, mst[k]};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int d = 0; d < 3; d++) begin
                mrd[k][d] = '0; mwr[k][d] = 1'b0; mld[k][d] = 1'b0;
            end
            mst[k] = 2'd0; msc[k] = 0; mfc[k] = 0;
        end
    endtask

    task automatic model_advance();
        for (int k = 0; k < 2; k++) begin
            logic stl, iss;
            stl = model_stall(k);
            iss = !stl && !exJr;
            for (int d = 2; d > 0; d--) begin
                mrd[k][d] = mrd[k][d-1]; mwr[k][d] = mwr[k][d-1]; mld[k][d] = mld[k][d-1];
            end
            mrd[k][0] = iss ? dRd : 5'd0;
            mwr[k][0] = iss && dWreg && (dRd != 5'd0);
            mld[k][0] = iss && dLoad;
            mst[k]    = exJr ? 2'd2 : (stl ? 2'd1 : 2'd0);
            if (exJr)     mfc[k]++;
            else if (stl) msc[k]++;
        end
    endtask

    task automatic apply(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                         input logic urt, input logic [4:0] rd, input logic wr,
                         input logic ld, input logic jr);
        dRs = rs; dRt = rt; dUseRs = urs; dUseRt = urt;
        dRd = rd; dWreg = wr; dLoad = ld; exJr = jr;
    endtask

    task automatic tick();
        model_advance();
        @(posedge Clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 0, 0, 0, 0, 0, 0);
            tick();
        end
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #12;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs(k) !== 10'b00_00_1111_00) begin
                $display("FAIL reset ls=%0d got=%b exp=%b", k + 1, obs(k), 10'b00_00_1111_00);
                errors++;
            end
        end
        Rst = 1'b0;
        tick();
    endtask

    task automatic test_fwd_alu();
        drain();
        for (int c = 0; c < 3; c++) begin
            case (c)
                0: apply(5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0);
                1: apply(5'd3, 5'd4, 1, 1, 5'd8, 1, 0, 0);
                default: apply(5'd3, 5'd9, 1, 0, 5'd10, 1, 0, 0);
            endcase
            @(negedge Clk);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs(k) !== model_out(k)) begin
                    $display("FAIL fwd_alu ls=%0d cyc=%0d got=%b exp=%b", k + 1, c, obs(k), model_out(k));
                    errors++;
                end
                if (c > 0) begin
                    checks++;
                    if (obs(k)[9:8] !== ((c == 1) ? 2'b01 : 2'b10)) begin
                        $display("FAIL fwd_alu_code ls=%0d cyc=%0d got=%b exp=%b", k + 1, c,
                                 obs(k)[9:8], (c == 1) ? 2'b01 : 2'b10);
                        errors++;
                    end
                end
            end
            tick();
        end
    endtask

    task automatic test_load_use();
        drain();
        for (int c = 0; c < 4; c++) begin
            if (c == 0) apply(5'd1, 5'd0, 1, 0, 5'd5, 1, 1, 0);
            else        apply(5'd6, 5'd5, 1, 1, 5'd7, 1, 0, 0);
            @(negedge Clk);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs(k) !== model_out(k)) begin
                    $display("FAIL load_use ls=%0d cyc=%0d got=%b exp=%b", k + 1, c, obs(k), model_out(k));
                    errors++;
                end
            end
            if (c == 1) begin
                checks++;
                if (obs(0)[5:2] !== 4'b0010 || obs(1)[5:2] !== 4'b0010) begin
                    $display("FAIL load_use_stall1 got=%b/%b exp=0010", obs(0)[5:2], obs(1)[5:2]);
                    errors++;
                end
            end
            if (c == 2) begin
                checks++;
                if ({obs(0)[7:6], obs(0)[5], obs(0)[1:0]} !== 5'b10_1_01) begin
                    $display("FAIL load_use_ls1_resume got=%b exp=%b", {obs(0)[7:6], obs(0)[5], obs(0)[1:0]}, 5'b10_1_01);
                    errors++;
                end
                checks++;
                if ({obs(1)[5], obs(1)[1:0]} !== 3'b0_01) begin
                    $display("FAIL load_use_ls2_second got=%b exp=%b", {obs(1)[5], obs(1)[1:0]}, 3'b0_01);
                    errors++;
                end
            end
            if (c == 3) begin
                checks++;
                if ({obs(1)[7:6], obs(1)[5], obs(1)[1:0]} !== 5'b11_1_01) begin
                    $display("FAIL load_use_ls2_resume got=%b exp=%b", {obs(1)[7:6], obs(1)[5], obs(1)[1:0]}, 5'b11_1_01);
                    errors++;
                end
            end
            tick();
        end
    endtask

    task automatic test_flush();
        drain();
        for (int c = 0; c < 3; c++) begin
            case (c)
                0: apply(5'd1, 5'd0, 1, 0, 5'd5, 1, 1, 0);
                1: apply(5'd6, 5'd5, 1, 1, 5'd7, 1, 0, 1);
                default: apply(5'd6, 5'd5, 1, 1, 5'd7, 1, 0, 0);
            endcase
            @(negedge Clk);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs(k) !== model_out(k)) begin
                    $display("FAIL flush ls=%0d cyc=%0d got=%b exp=%b", k + 1, c, obs(k), model_out(k));
                    errors++;
                end
                if (c == 1) begin
                    checks++;
                    if (obs(k)[5:2] !== 4'b1100) begin
                        $display("FAIL flush_ctl ls=%0d got=%b exp=1100", k + 1, obs(k)[5:2]);
                        errors++;
                    end
                end
                if (c == 2) begin
                    checks++;
                    if (obs(k)[1:0] !== 2'b10) begin
                        $display("FAIL flush_state ls=%0d got=%b exp=10", k + 1, obs(k)[1:0]);
                        errors++;
                    end
                end
            end
            tick();
        end
    endtask

    task automatic test_r0();
        drain();
        for (int c = 0; c < 3; c++) begin
            if (c == 0) apply(5'd1, 5'd0, 1, 0, 5'd0, 1, 1, 0);
            else        apply(5'd0, 5'd0, 1, 1, 5'd4, 1, 0, 0);
            @(negedge Clk);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs(k) !== model_out(k)) begin
                    $display("FAIL r0 ls=%0d cyc=%0d got=%b exp=%b", k + 1, c, obs(k), model_out(k));
                    errors++;
                end
                if (c > 0) begin
                    checks++;
                    if ({obs(k)[9:6], obs(k)[5]} !== 5'b0000_1) begin
                        $display("FAIL r0_nofwd ls=%0d got=%b exp=00001", k + 1, {obs(k)[9:6], obs(k)[5]});
                        errors++;
                    end
                end
            end
            tick();
        end
    endtask

    task automatic test_rst_mid_stall();
        drain();
        apply(5'd1, 5'd0, 1, 0, 5'd5, 1, 1, 0);
        tick();
        apply(5'd5, 5'd0, 1, 0, 5'd7, 1, 0, 0);
        tick();
        @(negedge Clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs(k) !== model_out(k)) begin
                $display("FAIL rst_pre ls=%0d got=%b exp=%b", k + 1, obs(k), model_out(k));
                errors++;
            end
        end
        #1 Rst = 1'b1;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs(k) !== 10'b00_00_1111_00) begin
                $display("FAIL rst_async ls=%0d got=%b exp=%b", k + 1, obs(k), 10'b00_00_1111_00);
                errors++;
            end
        end
`ifdef HAZ_PERF_EN
        checks++;
        if (sc1 !== 32'd0 || sc2 !== 32'd0) begin
            $display("FAIL rst_stallcnt got=%0d/%0d exp=0", sc1, sc2);
            errors++;
        end
`endif
        #1 Rst = 1'b0;
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            apply(5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)),
                  1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                  5'($urandom_range(7, 0)), 1'($urandom_range(3, 0) != 0),
                  ($urandom_range(9, 0) < 3), ($urandom_range(9, 0) == 0));
            @(negedge Clk);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs(k) !== model_out(k)) begin
                    $display("FAIL random ls=%0d cyc=%0d got=%b exp=%b", k + 1, c, obs(k), model_out(k));
                    errors++;
                end
            end
            tick();
        end
`ifdef HAZ_PERF_EN
        checks++;
        if (sc1 !== msc[0] || fc1 !== mfc[0] || sc2 !== msc[1] || fc2 !== mfc[1]) begin
            $display("FAIL perf_cnt got=%0d,%0d,%0d,%0d exp=%0d,%0d,%0d,%0d",
                     sc1, fc1, sc2, fc2, msc[0], mfc[0], msc[1], mfc[1]);
            errors++;
        end
`endif
    endtask

    initial begin
        test_reset();
        test_fwd_alu();
        test_load_use();
        test_flush();
        test_r0();
        test_rst_mid_stall();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
